// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_stage
// Description : EX/MEM pipeline register of the 5-stage RV32I pipeline.
//               Captures the EX-stage results and control once per cycle and
//               presents them as MEM_* to the memory stage and to the
//               forwarding/hazard unit. Supports hold (EX_MEM_en=0), bubble
//               insertion (EX_MEM_rst_n=0) and branch flush (flush=1), tracks
//               the slot state and flags runaway bubble sequences.
//
// Ports       : clk, rst (async, active-high)
//               EX_MEM_en, EX_MEM_rst_n, flush    - hazard / branch control
//               EX_valid, EX_pc, EX_alu_data, EX_st_data, EX_rd_addr,
//               EX_rd_wren, EX_mem_wren, EX_ld_en, EX_funct3, EX_wb_sel
//                                                 - EX-stage inputs
//               MEM_pc, MEM_alu_data, MEM_st_data, MEM_rd_addr, MEM_rd_wren,
//               MEM_mem_wren, MEM_ld_en, MEM_funct3, MEM_wb_sel, MEM_valid
//                                                 - registered MEM outputs
//               MEM_state (00 EMPTY, 01 VALID, 10 BUBBLE), stall_err (sticky)
//
// Options     : `define EX_MEM_PERF_EN adds perf_bubble_cnt / perf_flush_cnt
//               (32-bit wrapping counters of bubble-insert and flush cycles).
//
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int MAX_BUBBLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EX_MEM_en,
    input  logic              EX_MEM_rst_n,
    input  logic              flush,
    input  logic              EX_valid,
    input  logic [DATA_W-1:0] EX_pc,
    input  logic [DATA_W-1:0] EX_alu_data,
    input  logic [DATA_W-1:0] EX_st_data,
    input  logic [REG_AW-1:0] EX_rd_addr,
    input  logic              EX_rd_wren,
    input  logic              EX_mem_wren,
    input  logic              EX_ld_en,
    input  logic [2:0]        EX_funct3,
    input  logic [1:0]        EX_wb_sel,
    output logic [DATA_W-1:0] MEM_pc,
    output logic [DATA_W-1:0] MEM_alu_data,
    output logic [DATA_W-1:0] MEM_st_data,
    output logic [REG_AW-1:0] MEM_rd_addr,
    output logic              MEM_rd_wren,
    output logic              MEM_mem_wren,
    output logic              MEM_ld_en,
    output logic [2:0]        MEM_funct3,
    output logic [1:0]        MEM_wb_sel,
    output logic              MEM_valid,
    output logic [1:0]        MEM_state,
    output logic              stall_err
`ifdef EX_MEM_PERF_EN
    ,
    output logic [31:0]       perf_bubble_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'b00,
        ST_VALID  = 2'b01,
        ST_BUBBLE = 2'b10
    } state_t;

    // Counter must be able to hold MAX_BUBBLE+1 so that "exceeds" is visible.
    localparam int                 c_BUB_W     = $clog2(MAX_BUBBLE + 2);
    localparam logic [c_BUB_W-1:0] c_BUB_LIMIT = c_BUB_W'(MAX_BUBBLE);

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_valid;
    logic                r_rd_wren;
    logic                r_mem_wren;
    logic                r_ld_en;
    logic [DATA_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_alu_data;
    logic [DATA_W-1:0]   r_st_data;
    logic [REG_AW-1:0]   r_rd_addr;
    logic [2:0]          r_funct3;
    logic [1:0]          r_wb_sel;
    logic [c_BUB_W-1:0]  r_bub_cnt;
    logic                r_stall_err;

    logic                w_capture;
    logic                w_kill;
    logic [c_BUB_W-1:0]  w_bub_cnt_nxt;
    logic                w_stall_err_nxt;

    // ------------------------------------------------------------------------
    // Next-state / update decode. Priority: flush > bubble > hold > capture.
    // A bubble wins over hold because the hazard unit lowers both on load-use.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_capture     = 1'b0;
        w_kill        = 1'b0;
        w_bub_cnt_nxt = r_bub_cnt;

        if (flush) begin
            w_kill        = 1'b1;
            w_state_nxt   = ST_EMPTY;
            w_bub_cnt_nxt = '0;
        end else if (!EX_MEM_rst_n) begin
            w_kill      = 1'b1;
            w_state_nxt = ST_BUBBLE;
            if (r_bub_cnt != '1) begin
                w_bub_cnt_nxt = r_bub_cnt + 1'b1;
            end
        end else if (EX_MEM_en) begin
            w_capture     = 1'b1;
            w_state_nxt   = EX_valid ? ST_VALID : ST_EMPTY;
            w_bub_cnt_nxt = '0;
        end

        // Error is judged on the count after this edge so it rises together
        // with the offending bubble.
        w_stall_err_nxt = r_stall_err | (w_bub_cnt_nxt > c_BUB_LIMIT);
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Control bits: cleared by flush/bubble, loaded on capture, else held.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_rd_wren  <= 1'b0;
            r_mem_wren <= 1'b0;
            r_ld_en    <= 1'b0;
        end else if (w_kill) begin
            r_valid    <= 1'b0;
            r_rd_wren  <= 1'b0;
            r_mem_wren <= 1'b0;
            r_ld_en    <= 1'b0;
        end else if (w_capture) begin
            r_valid    <= EX_valid;
            r_rd_wren  <= EX_rd_wren;
            r_mem_wren <= EX_mem_wren;
            r_ld_en    <= EX_ld_en;
        end
    end

    // ------------------------------------------------------------------------
    // Data fields: only a capture changes them; flush and bubble leave them.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= '0;
            r_alu_data <= '0;
            r_st_data  <= '0;
            r_rd_addr  <= '0;
            r_funct3   <= '0;
            r_wb_sel   <= '0;
        end else if (w_capture) begin
            r_pc       <= EX_pc;
            r_alu_data <= EX_alu_data;
            r_st_data  <= EX_st_data;
            r_rd_addr  <= EX_rd_addr;
            r_funct3   <= EX_funct3;
            r_wb_sel   <= EX_wb_sel;
        end
    end

    // ------------------------------------------------------------------------
    // Runaway-bubble monitor
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bub_cnt   <= '0;
            r_stall_err <= 1'b0;
        end else begin
            r_bub_cnt   <= w_bub_cnt_nxt;
            r_stall_err <= w_stall_err_nxt;
        end
    end

`ifdef EX_MEM_PERF_EN
    // ------------------------------------------------------------------------
    // Performance counters. A simultaneous flush and bubble is one flush.
    // ------------------------------------------------------------------------
    logic [31:0] r_perf_bubble_cnt;
    logic [31:0] r_perf_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_bubble_cnt <= '0;
            r_perf_flush_cnt  <= '0;
        end else if (flush) begin
            r_perf_flush_cnt  <= r_perf_flush_cnt + 32'd1;
        end else if (!EX_MEM_rst_n) begin
            r_perf_bubble_cnt <= r_perf_bubble_cnt + 32'd1;
        end
    end

    assign perf_bubble_cnt = r_perf_bubble_cnt;
    assign perf_flush_cnt  = r_perf_flush_cnt;
`endif

    // ------------------------------------------------------------------------
    // Outputs. Control is gated by the slot-valid bit so a bubble or flushed
    // slot can never forward or write; writes to x0 are suppressed here.
    // ------------------------------------------------------------------------
    assign MEM_pc       = r_pc;
    assign MEM_alu_data = r_alu_data;
    assign MEM_st_data  = r_st_data;
    assign MEM_rd_addr  = r_rd_addr;
    assign MEM_funct3   = r_funct3;
    assign MEM_wb_sel   = r_wb_sel;
    assign MEM_valid    = r_valid;
    assign MEM_rd_wren  = r_valid & r_rd_wren & (r_rd_addr != '0);
    assign MEM_mem_wren = r_valid & r_mem_wren;
    assign MEM_ld_en    = r_valid & r_ld_en;
    assign MEM_state    = r_state;
    assign stall_err    = r_stall_err;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_stage
// Description : Self-checking bench for ex_mem_stage. A directed vector table
//               walks the main scenarios, short hand-written sequences cover
//               the multi-cycle corners (runaway bubbles, hold in BUBBLE,
//               async reset mid-bubble, flush priority), and a randomized
//               phase is checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;

    localparam int MAXB = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        EX_MEM_en, EX_MEM_rst_n, flush, EX_valid;
    logic [31:0] EX_pc, EX_alu_data, EX_st_data;
    logic [4:0]  EX_rd_addr;
    logic        EX_rd_wren, EX_mem_wren, EX_ld_en;
    logic [2:0]  EX_funct3;
    logic [1:0]  EX_wb_sel;
    logic [31:0] MEM_pc, MEM_alu_data, MEM_st_data;
    logic [4:0]  MEM_rd_addr;
    logic        MEM_rd_wren, MEM_mem_wren, MEM_ld_en, MEM_valid, stall_err;
    logic [2:0]  MEM_funct3;
    logic [1:0]  MEM_wb_sel;
    logic [1:0]  MEM_state;
`ifdef EX_MEM_PERF_EN
    logic [31:0] perf_bubble_cnt, perf_flush_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    ex_mem_stage #(.DATA_W(32), .REG_AW(5), .MAX_BUBBLE(MAXB)) dut (
        .clk(clk), .rst(rst),
        .EX_MEM_en(EX_MEM_en), .EX_MEM_rst_n(EX_MEM_rst_n), .flush(flush),
        .EX_valid(EX_valid), .EX_pc(EX_pc), .EX_alu_data(EX_alu_data),
        .EX_st_data(EX_st_data), .EX_rd_addr(EX_rd_addr),
        .EX_rd_wren(EX_rd_wren), .EX_mem_wren(EX_mem_wren), .EX_ld_en(EX_ld_en),
        .EX_funct3(EX_funct3), .EX_wb_sel(EX_wb_sel),
        .MEM_pc(MEM_pc), .MEM_alu_data(MEM_alu_data), .MEM_st_data(MEM_st_data),
        .MEM_rd_addr(MEM_rd_addr), .MEM_rd_wren(MEM_rd_wren),
        .MEM_mem_wren(MEM_mem_wren), .MEM_ld_en(MEM_ld_en),
        .MEM_funct3(MEM_funct3), .MEM_wb_sel(MEM_wb_sel),
        .MEM_valid(MEM_valid), .MEM_state(MEM_state), .stall_err(stall_err)
`ifdef EX_MEM_PERF_EN
        , .perf_bubble_cnt(perf_bubble_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl, rn, en, v;
        logic [4:0]  rd;
        logic        rdw, mw, ld;
        logic [31:0] alu, st;
        logic [1:0]  e_state;
        logic        e_v, e_rdw, e_mw, e_ld, e_err;
        logic [4:0]  e_rd;
        logic [31:0] e_alu, e_st;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(logic fl, logic rn, logic en, logic v, logic [4:0] rd,
                                logic rdw, logic mw, logic ld, logic [31:0] alu, logic [31:0] st,
                                logic [1:0] es, logic ev, logic erdw, logic emw, logic eld,
                                logic eerr, logic [4:0] erd, logic [31:0] ealu, logic [31:0] est);
        vec_t t;
        t.fl = fl; t.rn = rn; t.en = en; t.v = v; t.rd = rd;
        t.rdw = rdw; t.mw = mw; t.ld = ld; t.alu = alu; t.st = st;
        t.e_state = es; t.e_v = ev; t.e_rdw = erdw; t.e_mw = emw; t.e_ld = eld;
        t.e_err = eerr; t.e_rd = erd; t.e_alu = ealu; t.e_st = est;
        return t;
    endfunction

    // funct3/wb_sel are only meaningful (and compared) while the slot is valid
    function automatic logic [127:0] pk(logic [1:0] st, logic v, logic rdw, logic mw,
                                        logic ld, logic err, logic [4:0] rd,
                                        logic [31:0] alu, logic [31:0] sd,
                                        logic [31:0] pc, logic [4:0] fw);
        return {15'd0, st, v, rdw, mw, ld, err, rd, alu, sd, pc, (v ? fw : 5'd0)};
    endfunction

    function automatic logic [127:0] act();
        return pk(MEM_state, MEM_valid, MEM_rd_wren, MEM_mem_wren, MEM_ld_en, stall_err,
                  MEM_rd_addr, MEM_alu_data, MEM_st_data, MEM_pc, {MEM_funct3, MEM_wb_sel});
    endfunction

    task automatic check(string nm, logic [127:0] a, logic [127:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic drive(logic fl, logic rn, logic en, logic v, logic [4:0] rd,
                         logic rdw, logic mw, logic ld, logic [31:0] alu, logic [31:0] st);
        flush = fl; EX_MEM_rst_n = rn; EX_MEM_en = en; EX_valid = v;
        EX_rd_addr = rd; EX_rd_wren = rdw; EX_mem_wren = mw; EX_ld_en = ld;
        EX_alu_data = alu; EX_st_data = st;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        EX_pc = 0; EX_funct3 = 0; EX_wb_sel = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // behavioural model state
    logic [1:0]  m_state;
    logic        m_v, m_rdw, m_mw, m_ld, m_err;
    logic [4:0]  m_rd, m_fw;
    logic [31:0] m_alu, m_st, m_pc, m_pb, m_pf;
    int          m_bub;

    task automatic model_reset();
        m_state = 0; m_v = 0; m_rdw = 0; m_mw = 0; m_ld = 0; m_err = 0;
        m_rd = 0; m_fw = 0; m_alu = 0; m_st = 0; m_pc = 0; m_pb = 0; m_pf = 0; m_bub = 0;
    endtask

    initial begin
        rst = 1'b0;
        do_reset();
        check("reset_state", act(), 128'd0);

        // ---------------- directed table ----------------
        tbl[0]  = mk(0,1,1, 1,5,1,0,0, 32'h1234,0,      2'b01,1,1,0,0,0, 5,32'h1234,0);
        tbl[1]  = mk(0,1,1, 1,7,1,0,1, 32'h100,0,       2'b01,1,1,0,1,0, 7,32'h100,0);
        tbl[2]  = mk(0,0,0, 1,9,1,0,0, 32'h200,0,       2'b10,0,0,0,0,0, 7,32'h100,0);
        tbl[3]  = mk(0,1,1, 1,9,1,0,0, 32'h200,0,       2'b01,1,1,0,0,0, 9,32'h200,0);
        tbl[4]  = mk(1,0,1, 1,3,1,1,1, 32'h300,32'h55,  2'b00,0,0,0,0,0, 9,32'h200,0);
        tbl[5]  = mk(0,1,1, 1,4,1,0,0, 32'hAA,0,        2'b01,1,1,0,0,0, 4,32'hAA,0);
        tbl[6]  = mk(0,1,0, 1,6,1,1,0, 32'hBB,32'h77,   2'b01,1,1,0,0,0, 4,32'hAA,0);
        tbl[7]  = tbl[6];
        tbl[8]  = tbl[6];
        tbl[9]  = mk(0,1,1, 1,0,1,0,0, 32'h10,0,        2'b01,1,0,0,0,0, 0,32'h10,0);
        tbl[10] = mk(0,1,1, 1,2,0,1,0, 32'h20,32'hDEAD, 2'b01,1,0,1,0,0, 2,32'h20,32'hDEAD);
        tbl[11] = mk(0,1,1, 0,3,1,1,1, 32'h30,0,        2'b00,0,0,0,0,0, 3,32'h30,0);
        tbl[12] = mk(0,1,0, 1,8,1,0,0, 32'h40,0,        2'b00,0,0,0,0,0, 3,32'h30,0);

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].fl, tbl[i].rn, tbl[i].en, tbl[i].v, tbl[i].rd,
                  tbl[i].rdw, tbl[i].mw, tbl[i].ld, tbl[i].alu, tbl[i].st);
            step();
            check($sformatf("table[%0d]", i), act(),
                  pk(tbl[i].e_state, tbl[i].e_v, tbl[i].e_rdw, tbl[i].e_mw, tbl[i].e_ld,
                     tbl[i].e_err, tbl[i].e_rd, tbl[i].e_alu, tbl[i].e_st, 32'd0, 5'd0));
        end
`ifdef EX_MEM_PERF_EN
        check("table_perf", {64'd0, perf_bubble_cnt, perf_flush_cnt}, {64'd0, 32'd1, 32'd1});
`endif

        // ---------------- runaway bubbles ----------------
        do_reset();
        drive(0,1,1, 1,5,1,0,0, 32'h1,0); step();
        drive(0,0,0, 1,5,1,0,0, 32'h2,0); step();
        check("runaway_b1", {126'd0, MEM_state}, {126'd0, 2'b10});
        check("runaway_b1_err", {127'd0, stall_err}, 128'd0);
        step();
        check("runaway_b2_err", {127'd0, stall_err}, 128'd1);
        drive(0,1,1, 1,6,1,0,0, 32'h3,0); step();
        check("runaway_after", {125'd0, stall_err, MEM_state}, {125'd0, 1'b1, 2'b01});
        step(); step();
        check("runaway_sticky", {127'd0, stall_err}, 128'd1);

        // ---------------- hold while in BUBBLE ----------------
        do_reset();
        drive(0,0,1, 1,5,1,0,0, 32'h1,0); step();
        drive(0,1,0, 1,5,1,0,0, 32'h1,0); step(); step();
        check("bubble_hold", {124'd0, stall_err, MEM_valid, MEM_state}, {124'd0, 2'b00, 2'b10});
        drive(0,0,1, 1,5,1,0,0, 32'h1,0); step();
        check("bubble_hold_then_b", {127'd0, stall_err}, 128'd1);

        // ---------------- capture clears the count ----------------
        do_reset();
        drive(0,0,1, 1,5,1,0,0, 32'h1,0); step();
        drive(0,1,1, 1,5,1,0,0, 32'h1,0); step();
        drive(0,0,1, 1,5,1,0,0, 32'h1,0); step();
        check("bubble_cleared", {125'd0, stall_err, MEM_state}, {125'd0, 1'b0, 2'b10});

        // ---------------- async reset mid-bubble ----------------
        drive(0,1,0, 1,5,1,0,0, 32'h1,0);
        rst = 1'b1; #1;
        check("async_reset", act(), 128'd0);
        #1 rst = 1'b0;
        drive(0,1,1, 1,5,1,0,0, 32'h77,0); step();
        check("after_reset_cap", act(), pk(2'b01,1,1,0,0,0, 5,32'h77,0,0,0));

        // ---------------- flush over bubble ----------------
        do_reset();
        drive(1,0,1, 1,5,1,1,1, 32'h9,32'h9); step();
        check("flush_prio", act(), 128'd0);
`ifdef EX_MEM_PERF_EN
        check("flush_perf", {64'd0, perf_bubble_cnt, perf_flush_cnt}, {64'd0, 32'd0, 32'd1});
`endif

        // ---------------- randomized vs model ----------------
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            logic fl, rn, en, v, rdw, mw, ld;
            logic [4:0] rd;
            logic [31:0] alu, sd, pc;
            logic [2:0] f3;
            logic [1:0] wb;
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1; #1;
                check("rand_async_reset", act(), 128'd0);
                #1 rst = 1'b0;
                model_reset();
            end
            fl = ($urandom_range(0, 7) == 0);
            rn = ($urandom_range(0, 5) != 0);
            en = ($urandom_range(0, 4) != 0);
            v = $urandom_range(0, 3) != 0;
            rd = 5'($urandom_range(0, 7));
            rdw = 1'($urandom); mw = 1'($urandom); ld = 1'($urandom);
            alu = $urandom; sd = $urandom; pc = $urandom;
            f3 = 3'($urandom); wb = 2'($urandom);
            drive(fl, rn, en, v, rd, rdw, mw, ld, alu, sd);
            EX_pc = pc; EX_funct3 = f3; EX_wb_sel = wb;
            step();
            if (fl) begin
                m_v = 0; m_state = 2'b00; m_bub = 0; m_pf = m_pf + 1;
            end else if (!rn) begin
                m_v = 0; m_state = 2'b10; m_bub = m_bub + 1; m_pb = m_pb + 1;
                if (m_bub > MAXB) m_err = 1;
            end else if (en) begin
                m_v = v; m_rdw = rdw; m_mw = mw; m_ld = ld; m_rd = rd;
                m_alu = alu; m_st = sd; m_pc = pc; m_fw = {f3, wb};
                m_state = v ? 2'b01 : 2'b00; m_bub = 0;
            end
            check($sformatf("rand[%0d]", c), act(),
                  pk(m_state, m_v, m_v & m_rdw & (m_rd != 0), m_v & m_mw, m_v & m_ld,
                     m_err, m_rd, m_alu, m_st, m_pc, m_fw));
`ifdef EX_MEM_PERF_EN
            check($sformatf("rand_perf[%0d]", c), {64'd0, perf_bubble_cnt, perf_flush_cnt},
                  {64'd0, m_pb, m_pf});
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline register of the 5-stage RV32I pipeline; captures EX results and control each cycle.
- Produces the MEM_* signals that the forwarding/hazard unit consumes: MEM_rd_addr, MEM_rd_wren, MEM_mem_wren, MEM_ld_en.
- Obeys EX_MEM_en (hold) and EX_MEM_rst_n (bubble insert) from the hazard unit, plus a branch-flush input.
- Tracks slot state and checks for runaway bubble sequences.

Parameters:
- DATA_W, 32, width of ALU result, store data and PC
- REG_AW, 5, register address width
- MAX_BUBBLE, 1, max consecutive bubble cycles before stall_err is raised

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- EX_MEM_en  in  1  1 = load new EX values; 0 = hold
- EX_MEM_rst_n  in  1  0 = insert bubble this cycle (synchronous)
- flush  in  1  synchronous kill of the captured instruction (taken branch/jump)
- EX_valid  in  1  EX slot holds a real instruction
- EX_pc  in  DATA_W  instruction PC
- EX_alu_data  in  DATA_W  ALU result / memory address
- EX_st_data  in  DATA_W  forwarded rs2 value for stores
- EX_rd_addr  in  REG_AW  destination register
- EX_rd_wren, EX_mem_wren, EX_ld_en  in  1 each  control bits
- EX_funct3  in  3  load/store size and sign
- EX_wb_sel  in  2  writeback source select
- MEM_pc, MEM_alu_data, MEM_st_data  out  DATA_W  registered copies
- MEM_rd_addr  out  REG_AW  registered rd
- MEM_rd_wren, MEM_mem_wren, MEM_ld_en  out  1  registered control, gated by MEM_valid
- MEM_funct3  out  3, MEM_wb_sel  out  2  registered copies
- MEM_valid  out  1  MEM slot holds a real instruction
- MEM_state  out  2  00 EMPTY, 01 VALID, 10 BUBBLE
- stall_err  out  1  sticky error flag

Behaviour:
- Reset (rst=1, asynchronous): every output and register goes to 0. MEM_state=EMPTY, stall_err=0.
- Update priority per rising edge:
  - flush=1: clear all control bits and MEM_valid; data fields hold. Next state EMPTY.
  - else EX_MEM_rst_n=0: insert bubble. Same clearing as flush; next state BUBBLE. This applies even when EX_MEM_en=0; the hazard unit drives both low on load-use.
  - else EX_MEM_en=0: hold all registers; state unchanged.
  - else: capture all EX_* fields. MEM_valid=EX_valid. Next state VALID if EX_valid=1, else EMPTY.
- Control outputs are the registered bits ANDed with MEM_valid, so a bubble or flush never forwards or writes.
- MEM_rd_wren is forced to 0 when the captured EX_rd_addr=0; MEM_rd_addr keeps the captured value.
- Latency: 1 cycle from EX_* to MEM_*. No combinational input-to-output path.
- Bubble counter:
  - Saturating, width clog2(MAX_BUBBLE+2).
  - Increments each cycle the stage enters BUBBLE; clears on any transition to VALID or EMPTY.
  - When count exceeds MAX_BUBBLE, stall_err is set to 1 and stays set until rst.
- Hold while in BUBBLE keeps the BUBBLE state, and the counter does not increment.
- A store (EX_mem_wren=1, EX_rd_wren=0) passes through: MEM_mem_wren=1, MEM_rd_wren=0.
- rst asserted mid-hold or mid-bubble: immediate clear; the first edge after release behaves as normal capture.

Optional Feature:
- Macro: EX_MEM_PERF_EN.
- When defined, adds outputs perf_bubble_cnt (32 bits) and perf_flush_cnt (32 bits).
  - They count bubble-insert cycles and flush cycles respectively.
  - Both wrap at 2^32 and reset to 0 on rst.
  - A cycle with flush and EX_MEM_rst_n=0 together counts only as a flush.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then capture. rst pulse, then EX_valid=1, EX_rd_addr=5, EX_rd_wren=1, EX_alu_data=0x1234 -> after 1 edge: MEM_rd_addr=5, MEM_rd_wren=1, MEM_alu_data=0x1234, MEM_state=01.
- Load-use bubble. Load to x7 in MEM; drive EX_MEM_en=0 and EX_MEM_rst_n=0 for 1 cycle -> MEM_valid=0, MEM_ld_en=0, MEM_rd_wren=0, MEM_state=10, stall_err=0. Next normal cycle -> MEM_state=01.
- Flush priority. flush=1 with EX_MEM_rst_n=0 and EX_valid=1 -> MEM_state=00, all control outputs 0. With EX_MEM_PERF_EN: perf_flush_cnt +1, perf_bubble_cnt unchanged.
- Hold. Capture EX_alu_data=0xAA, then EX_MEM_en=0 for 3 cycles while EX_alu_data=0xBB -> MEM_alu_data stays 0xAA for all 3 cycles.
- x0 and store. Capture EX_rd_addr=0, EX_rd_wren=1 -> MEM_rd_wren=0. Capture a store with EX_mem_wren=1, EX_st_data=0xDEAD -> MEM_mem_wren=1, MEM_st_data=0xDEAD.
- Runaway bubbles. EX_MEM_rst_n=0 for 2 consecutive cycles with MAX_BUBBLE=1 -> stall_err=1 after the second edge, and it remains 1 through later normal traffic until rst.
